network_mul_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that time-shares one pipelined 16s x 12ns -> 28s multiplier among NUM_REQ requesters.
- Drives the multiplier's ce/din0/din1 and tracks request tags through the multiplier pipeline.
- Returns each product to the output port tagged with the originating requester.
- Stalls the whole multiplier pipeline through ce when the consumer applies backpressure.

---
 rtl/network_mul_share_arb.sv | 89 ++++++++
 tb/tb_network_mul_share_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/network_mul_share_arb.sv
// Round-robin arbiter that time-shares one external pipelined 16s x 12u multiplier
// among NUM_REQ requesters, tracking tags alongside the multiplier pipeline.
module network_mul_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [12*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  mul_ce,
  output logic [15:0]           mul_din0,
  output logic [11:0]           mul_din1,
  input  logic [27:0]           mul_dout,
  output logic                  res_valid,
  output logic [27:0]           res_data,
  output logic [TAG_W-1:0]      res_tag,
  input  logic                  res_ready
);

  logic [TAG_W-1:0]       rr_ptr;
  logic [TAG_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   issue;
  logic                   stall;
  logic [TAG_W:0]         cand;
  logic [MUL_LATENCY-1:0] vld_pipe;
  logic [TAG_W-1:0]       tag_pipe [MUL_LATENCY];

  // A held result freezes everything, including the multiplier itself via ce.
  assign res_valid = vld_pipe[MUL_LATENCY-1] & ~reset;
  assign res_tag   = tag_pipe[MUL_LATENCY-1];
  assign res_data  = mul_dout;
  assign stall     = res_valid & ~res_ready;
  assign mul_ce    = ~stall & ~reset;
  assign issue     = mul_ce & grant_any;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (cand >= (TAG_W+1)'(NUM_REQ))
        cand = cand - (TAG_W+1)'(NUM_REQ);
      if (!grant_any && req_valid[cand[TAG_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
      mul_din0 = req_a[grant_idx*16 +: 16];
      mul_din1 = req_b[grant_idx*12 +: 12];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      vld_pipe <= '0;
    end else if (mul_ce) begin
      if (grant_any)
        rr_ptr <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      vld_pipe[0] <= grant_any;
      for (int i = 1; i < MUL_LATENCY; i++)
        vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Tags need no reset: a stale tag is never visible while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      tag_pipe[0] <= grant_idx;
      for (int i = 1; i < MUL_LATENCY; i++)
        tag_pipe[i] <= tag_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_network_mul_share_arb.sv
// Randomized scoreboard bench for network_mul_share_arb, with a behavioural
// multiplier model standing in for the external pipelined multiplier.
module tb_network_mul_share_arb;

  localparam int NUM_REQ     = 4;
  localparam int MUL_LATENCY = 2;
  localparam int TAG_W       = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [16*NUM_REQ-1:0] req_a = '0;
  logic [12*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mul_ce;
  logic [15:0]           mul_din0;
  logic [11:0]           mul_din1;
  logic [27:0]           mul_dout;
  logic                  res_valid;
  logic [27:0]           res_data;
  logic [TAG_W-1:0]      res_tag;
  logic                  res_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int tag;
    int prod;
    int due;
  } exp_t;
  exp_t exp_q[$];

  network_mul_share_arb #(
    .NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Multiplier model: product enters the first stage on a ce edge, advances only on ce.
  logic signed [27:0] mpipe [MUL_LATENCY];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= 28'($signed(mul_din0) * $signed({1'b0, mul_din1}));
      for (int i = 1; i < MUL_LATENCY; i++)
        mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[MUL_LATENCY-1];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setOperand(input int idx, input logic signed [15:0] a, input logic [11:0] b);
    req_a[idx*16 +: 16] = a;
    req_b[idx*12 +: 12] = b;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic rr);
    req_valid = v;
    res_ready = rr;
    @(posedge clk);
    #1;
  endtask

  // Issue side: reference round-robin arbiter pushes expected results.
  int ref_ptr = 0;
  int cnt_a   = 0;
  always @(negedge clk) begin
    int g;
    logic stalled;
    if (reset) begin
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_mul_ce", mul_ce, 0);
      checkOutput("rst_mul_din0", mul_din0, 0);
      exp_q.delete();
      ref_ptr = 0;
      cnt_a   = 0;
    end else begin
      stalled = res_valid && !res_ready;
      checkOutput("mul_ce", mul_ce, stalled ? 0 : 1);
      if (stalled) begin
        checkOutput("stall_req_ready", req_ready, 0);
      end else begin
        g = -1;
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && req_valid[(ref_ptr + k) % NUM_REQ]) g = (ref_ptr + k) % NUM_REQ;
        if (g >= 0) begin
          logic signed [15:0] a;
          logic [11:0] b;
          exp_t e;
          a = req_a[g*16 +: 16];
          b = req_b[g*12 +: 12];
          checkOutput("req_ready", req_ready, longint'(1) << g);
          checkOutput("mul_din0", mul_din0, longint'(a[15:0]));
          checkOutput("mul_din1", mul_din1, longint'(b));
          e.tag  = g;
          e.prod = int'(a) * int'(b);
          e.due  = cnt_a + MUL_LATENCY;
          exp_q.push_back(e);
          ref_ptr = (g + 1) % NUM_REQ;
        end else begin
          checkOutput("idle_req_ready", req_ready, 0);
          checkOutput("idle_mul_din0", mul_din0, 0);
          checkOutput("idle_mul_din1", mul_din1, 0);
        end
        cnt_a++;
      end
    end
  end

  // Result side: a result must appear exactly when its issue has aged MUL_LATENCY ce cycles.
  int cnt_b = 0;
  logic was_stalled = 1'b0;
  logic [27:0] held_data;
  logic [TAG_W-1:0] held_tag;
  always @(negedge clk) begin
    logic due;
    if (reset) begin
      cnt_b       = 0;
      was_stalled = 1'b0;
    end else begin
      due = (exp_q.size() > 0) && (exp_q[0].due == cnt_b);
      checkOutput("res_valid", res_valid, due);
      if (was_stalled) begin
        checkOutput("hold_data", res_data, held_data);
        checkOutput("hold_tag", res_tag, held_tag);
      end
      if (res_valid && due) begin
        checkOutput("res_tag", res_tag, exp_q[0].tag);
        checkOutput("res_data", longint'($signed(res_data)), exp_q[0].prod);
        if (res_ready) void'(exp_q.pop_front());
      end
      was_stalled = res_valid && !res_ready;
      held_data   = res_data;
      held_tag    = res_tag;
      if (!(res_valid && !res_ready)) cnt_b++;
    end
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) setOperand(i, 16'sd0, 12'd0);
    repeat (3) applyStimulus('0, 1'b1);
    reset = 1'b0;

    // Single request from requester 1
    setOperand(1, -16'sd7, 12'd100);
    applyStimulus(4'b0010, 1'b1);
    repeat (3) applyStimulus('0, 1'b1);

    // All requesters valid from pointer 0
    reset = 1'b1;
    applyStimulus('0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) setOperand(i, 16'(i * 37 - 50), 12'(i * 11 + 3));
    repeat (5) applyStimulus(4'b1111, 1'b1);
    repeat (3) applyStimulus('0, 1'b1);

    // Extremes
    setOperand(0, -16'sd32768, 12'd4095);
    applyStimulus(4'b0001, 1'b1);
    setOperand(1, 16'sd32767, 12'd4095);
    applyStimulus(4'b0010, 1'b1);
    setOperand(2, -16'sd1, 12'd0);
    applyStimulus(4'b0100, 1'b1);
    repeat (3) applyStimulus('0, 1'b1);

    // Backpressure while results are in flight
    setOperand(3, 16'sd1234, 12'd567);
    applyStimulus(4'b1000, 1'b1);
    setOperand(3, -16'sd999, 12'd321);
    applyStimulus(4'b1000, 1'b1);
    setOperand(3, 16'sd42, 12'd4000);
    repeat (5) applyStimulus(4'b1000, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    repeat (4) applyStimulus('0, 1'b1);

    // Reset with two results in flight
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b1000, 1'b1);
    reset = 1'b1;
    applyStimulus('0, 1'b1);
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    repeat (4) applyStimulus('0, 1'b1);

    // Sparse requester 2 leaves bubbles in the pipeline
    for (int c = 0; c < 12; c++) begin
      setOperand(2, 16'(c * 100 - 600), 12'(c + 1));
      applyStimulus((c % 3 == 0) ? 4'b0100 : 4'b0000, 1'b1);
    end

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) setOperand(i, 16'($urandom), 12'($urandom));
      applyStimulus(NUM_REQ'($urandom), $urandom_range(0, 3) != 0);
    end

    repeat (10) applyStimulus('0, 1'b1);
    checkOutput("drain_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
